// File: rtl/linefill_engine.sv
`default_nettype none
// ============================================================================
// Module      : linefill_engine
// Description : Critical-word-first cache line fill. Collects eight 32-bit
//               beats into one 256-bit line, then issues a single RAM write.
// Revision    : 1.0 - initial release
// ============================================================================
module linefill_engine #(
  parameter int LSS = 8,
  parameter int NL  = 256
) (
  input  logic           nGCLK,
  input  logic           reset,
  input  logic           fill_req,
  input  logic [LSS-1:0] fill_line,
  input  logic [2:0]     fill_word,
  output logic           fill_busy,
  input  logic           mem_valid,
  input  logic [31:0]    mem_data,
  output logic           mem_ready,
  output logic           crit_valid,
  output logic [31:0]    crit_data,
  output logic [LSS-1:0] write_sel,
  output logic [255:0]   write_port,
  output logic           wr_ena,
  output logic           fill_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Keeps the latched line index inside the NL-line array.
  localparam logic [LSS-1:0] c_LINE_MASK = LSS'(NL - 1);

  state_t         state_q,      state_d;
  logic [LSS-1:0] line_q,       line_d;
  logic [2:0]     word_q,       word_d;
  logic [2:0]     cnt_q,        cnt_d;
  logic [255:0]   line_buf_q,   line_buf_d;
  logic           crit_valid_q, crit_valid_d;
  logic [31:0]    crit_data_q,  crit_data_d;
  logic [LSS-1:0] wsel_q,       wsel_d;
  logic [255:0]   wport_q,      wport_d;
  logic [2:0]     slot;

  // Wrap-around slot placement gives critical-word-first ordering.
  assign slot = word_q + cnt_q;

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    line_buf_d   = line_buf_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    wsel_d       = wsel_q;
    wport_d      = wport_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_req) begin
          line_d  = fill_line & c_LINE_MASK;
          word_d  = fill_word;
          cnt_d   = 3'd0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_valid) begin
          line_buf_d[{slot, 5'b00000} +: 32] = mem_data;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd0) begin
            crit_data_d  = mem_data;
            crit_valid_d = 1'b1;
          end
          // The output line register only changes when a fill completes.
          if (cnt_q == 3'd7) begin
            wsel_d  = line_q;
            wport_d = line_buf_d;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nGCLK) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      word_q       <= 3'd0;
      cnt_q        <= 3'd0;
      line_buf_q   <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= 32'd0;
      wsel_q       <= '0;
      wport_q      <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      line_buf_q   <= line_buf_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      wsel_q       <= wsel_d;
      wport_q      <= wport_d;
    end
  end

  assign fill_busy  = (state_q != ST_IDLE);
  assign mem_ready  = (state_q == ST_FILL);
  assign wr_ena     = (state_q == ST_WRITE);
  assign fill_done  = (state_q == ST_WRITE);
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign write_sel  = wsel_q;
  assign write_port = wport_q;

endmodule
`default_nettype wire

// File: tb/tb_linefill_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_linefill_engine
// Description : Randomized bench for linefill_engine against a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linefill_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         fill_req;
  logic [7:0]   fill_line;
  logic [2:0]   fill_word;
  logic         mem_valid;
  logic [31:0]  mem_data;
  logic         fill_busy, mem_ready, crit_valid, wr_ena, fill_done;
  logic [31:0]  crit_data;
  logic [7:0]   write_sel;
  logic [255:0] write_port;
  logic         fill_busy6, mem_ready6, crit_valid6, wr_ena6, fill_done6;
  logic [31:0]  crit_data6;
  logic [5:0]   write_sel6;
  logic [255:0] write_port6;

  always #5 clk = ~clk;

  linefill_engine #(.LSS(8), .NL(256)) u_dut (
    .nGCLK(clk), .reset(reset), .fill_req(fill_req), .fill_line(fill_line),
    .fill_word(fill_word), .fill_busy(fill_busy), .mem_valid(mem_valid),
    .mem_data(mem_data), .mem_ready(mem_ready), .crit_valid(crit_valid),
    .crit_data(crit_data), .write_sel(write_sel), .write_port(write_port),
    .wr_ena(wr_ena), .fill_done(fill_done)
  );

  linefill_engine #(.LSS(6), .NL(64)) u_dut6 (
    .nGCLK(clk), .reset(reset), .fill_req(fill_req), .fill_line(fill_line[5:0]),
    .fill_word(fill_word), .fill_busy(fill_busy6), .mem_valid(mem_valid),
    .mem_data(mem_data), .mem_ready(mem_ready6), .crit_valid(crit_valid6),
    .crit_data(crit_data6), .write_sel(write_sel6), .write_port(write_port6),
    .wr_ena(wr_ena6), .fill_done(fill_done6)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Line-level model: a fill in progress with a count of beats received.
  bit           m_active;
  int           m_n;
  logic [7:0]   m_line;
  int           m_word;
  logic [31:0]  m_words [8];
  bit           m_crit_pulse;
  logic [31:0]  m_crit;
  logic [7:0]   m_wsel;
  logic [255:0] m_wport;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_active = 0; m_n = 0; m_crit_pulse = 0; m_crit = '0; m_wsel = '0; m_wport = '0;
    end else begin
      m_crit_pulse = 0;
      if (!m_active) begin
        if (fill_req) begin
          m_active = 1; m_n = 0; m_line = fill_line; m_word = int'(fill_word);
        end
      end else if (m_n < 8) begin
        if (mem_valid) begin
          m_words[(m_word + m_n) % 8] = mem_data;
          if (m_n == 0) begin
            m_crit = mem_data;
            m_crit_pulse = 1;
          end
          m_n++;
          if (m_n == 8) begin
            m_wsel = m_line;
            for (int k = 0; k < 8; k++) m_wport[32*k +: 32] = m_words[k];
          end
        end
      end else begin
        m_active = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit w;
    w = m_active && (m_n == 8);
    check("fill_busy",  256'(fill_busy),  256'(m_active));
    check("mem_ready",  256'(mem_ready),  256'(m_active && m_n < 8));
    check("wr_ena",     256'(wr_ena),     256'(w));
    check("fill_done",  256'(fill_done),  256'(w));
    check("crit_valid", 256'(crit_valid), 256'(m_crit_pulse));
    check("crit_data",  256'(crit_data),  256'(m_crit));
    check("write_sel",  256'(write_sel),  256'(m_wsel));
    check("write_port", write_port,       m_wport);
    check("wr_ena6",    256'(wr_ena6),    256'(w));
    check("write_sel6", 256'(write_sel6), 256'(m_wsel[5:0]));
    check("write_port6", write_port6,     m_wport);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  // noise: 0 quiet, 1 random fill_req/fill_line, 2 fill_req held with line C3.
  task automatic do_fill(input logic [7:0] line, input logic [2:0] word, input logic [31:0] base,
                         input int mode, input int noise, input int abort_at,
                         output int crit_cyc, output int wr_cyc, output logic [31:0] crit_seen);
    int start;
    int i;
    crit_cyc = -1; wr_cyc = -1; crit_seen = '0;
    fill_req = 1'b1; fill_line = line; fill_word = word; mem_valid = 1'b0;
    start = cyc;
    tick();
    fill_req = 1'b0;
    i = 0;
    while (m_active && m_n < 8 && i < 200) begin
      if (abort_at >= 0 && m_n == abort_at) begin
        reset = 1'b1; fill_req = 1'b1; mem_valid = 1'b1; mem_data = 32'($urandom);
        tick();
        reset = 1'b0; fill_req = 1'b0; mem_valid = 1'b0;
        return;
      end
      case (mode)
        0:       mem_valid = 1'b1;
        1:       mem_valid = (i % 2 == 0);
        default: mem_valid = ($urandom_range(2, 0) != 0);
      endcase
      mem_data = mem_valid ? base + 32'(m_n) : 32'($urandom);
      if (noise == 1) begin
        fill_req = ($urandom_range(1, 0) == 1); fill_line = 8'($urandom);
      end else if (noise == 2) begin
        fill_req = 1'b1; fill_line = 8'hC3;
      end
      tick();
      i++;
      if (crit_valid) begin
        crit_cyc = cyc - start; crit_seen = crit_data;
      end
    end
    if (i >= 200) begin
      tests++; fails++;
      $display("FAIL fill_timeout: got no completion after %0d cycles expected 8 beats", i);
    end
    if (wr_ena) wr_cyc = cyc - start;
    mem_valid = 1'b0;
    if (noise == 0) fill_req = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cc, wc, ab;
    logic [31:0]  cs;
    logic [255:0] lit;
    reset = 1'b1; fill_req = 1'b0; fill_line = '0; fill_word = '0;
    mem_valid = 1'b0; mem_data = '0;
    m_active = 0; m_n = 0; m_crit_pulse = 0; m_crit = '0; m_wsel = '0; m_wport = '0;
    for (int k = 0; k < 8; k++) m_words[k] = '0;
    tick(); tick();
    check("rst_busy",  256'(fill_busy), 256'(0));
    check("rst_ready", 256'(mem_ready), 256'(0));
    check("rst_wport", write_port, 256'(0));
    check("rst_crit",  256'(crit_data), 256'(0));
    reset = 1'b0;
    tick();

    // Back-to-back, critical word 0.
    do_fill(8'h2A, 3'd0, 32'h0, 0, 0, -1, cc, wc, cs);
    lit = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
    check("b2b_crit_cycle", 256'(cc), 256'(2));
    check("b2b_crit_data",  256'(cs), 256'(0));
    check("b2b_wr_cycle",   256'(wc), 256'(9));
    check("b2b_write_sel",  256'(write_sel), 256'(8'h2A));
    check("b2b_write_port", write_port, lit);
    check("b2b_model_port", m_wport, lit);

    // Wrap-around placement from word 5.
    do_fill(8'h11, 3'd5, 32'hA0, 0, 0, -1, cc, wc, cs);
    lit = {32'hA2, 32'hA1, 32'hA0, 32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3};
    check("wrap_crit_data",  256'(cs), 256'(32'hA0));
    check("wrap_write_port", write_port, lit);

    // Alternating mem_valid stalls.
    do_fill(8'h05, 3'd2, 32'hB00, 1, 0, -1, cc, wc, cs);
    check("toggle_crit_cycle", 256'(cc), 256'(2));
    check("toggle_wr_cycle",   256'(wc), 256'(16));

    // Reset after four beats, then a clean fill.
    do_fill(8'h77, 3'd1, 32'hC00, 0, 0, 4, cc, wc, cs);
    check("abort_busy",   256'(fill_busy),  256'(0));
    check("abort_wr_ena", 256'(wr_ena),     256'(0));
    check("abort_wport",  write_port,       256'(0));
    check("abort_wsel",   256'(write_sel),  256'(0));
    check("abort_crit",   256'(crit_data),  256'(0));
    do_fill(8'h78, 3'd3, 32'hD00, 0, 0, -1, cc, wc, cs);
    check("after_abort_wsel", 256'(write_sel), 256'(8'h78));
    check("after_abort_wc",   256'(wc), 256'(9));

    // fill_req held through a fill with another line: ignored until IDLE.
    do_fill(8'h44, 3'd6, 32'hE00, 0, 2, -1, cc, wc, cs);
    check("hold_wsel", 256'(write_sel), 256'(8'h44));
    check("hold_idle", 256'(fill_busy), 256'(0));
    do_fill(8'hC3, 3'd0, 32'hF00, 0, 0, -1, cc, wc, cs);
    check("hold_second_wsel", 256'(write_sel), 256'(8'hC3));

    // Narrow-index instance.
    do_fill(8'h3F, 3'd4, 32'h300, 0, 0, -1, cc, wc, cs);
    check("lss6_wsel", 256'(write_sel6), 256'(6'h3F));
    do_fill(8'hFF, 3'd7, 32'h400, 2, 0, -1, cc, wc, cs);
    check("lss6_wsel_mask", 256'(write_sel6), 256'(6'h3F));

    // Randomized fills.
    for (int r = 0; r < 40; r++) begin
      ab = ($urandom_range(5, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      do_fill(8'($urandom), 3'($urandom), 32'($urandom), int'($urandom_range(2, 0)),
              int'($urandom_range(1, 0)), ab, cc, wc, cs);
      fill_req = 1'b0;
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/linefill_engine.md
LINEFILL_ENGINE -- requirements
Module: linefill_engine

Interface
- REQ-001: Parameter LSS, default 8, line-select width (log2 of cache line count).
- REQ-002: Parameter NL, default 256, number of cache lines; NL = 2**LSS.
- REQ-003: nGCLK  input  1  single clock; all state updates on posedge nGCLK.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: fill_req  input  1  request to fill one cache line; sampled only in IDLE.
- REQ-006: fill_line  input  LSS  target line index; latched with fill_req.
- REQ-007: fill_word  input  3  critical word offset within line; latched with fill_req.
- REQ-008: fill_busy  output  1  high whenever state is not IDLE.
- REQ-009: mem_valid  input  1  memory beat valid.
- REQ-010: mem_data  input  32  memory beat data.
- REQ-011: mem_ready  output  1  engine accepts a beat this cycle.
- REQ-012: crit_valid  output  1  one-cycle pulse forwarding the critical word to the core.
- REQ-013: crit_data  output  32  critical word; valid when crit_valid=1.
- REQ-014: write_sel  output  LSS  cache RAM write line select.
- REQ-015: write_port  output  256  cache RAM write data.
- REQ-016: wr_ena  output  1  cache RAM write enable, one cycle per fill.
- REQ-017: fill_done  output  1  one-cycle pulse, coincident with wr_ena.

Function
- REQ-018: States SHALL be IDLE, FILL and WRITE.
- REQ-019: In IDLE, fill_req=1 SHALL latch fill_line and fill_word, clear the beat counter to 0 and enter FILL next cycle.
- REQ-020: fill_req outside IDLE SHALL be ignored (no queuing).
- REQ-021: mem_ready SHALL be 1 exactly while in FILL; a beat is accepted when mem_valid & mem_ready.
- REQ-022: Beat n (n = 0..7, acceptance order) SHALL be stored in slot s = (fill_word + n) mod 8; slot s occupies write_port bits [32s+31:32s] (wrap-around, critical-word-first).
- REQ-023: The beat counter SHALL advance only on an accepted beat; cycles with mem_valid=0 SHALL stall with no state change.
- REQ-024: On acceptance of beat 0, crit_data SHALL load mem_data and crit_valid SHALL pulse high for exactly the following cycle.
- REQ-025: On acceptance of beat 7, the FSM SHALL enter WRITE next cycle.
- REQ-026: In WRITE, wr_ena=1, fill_done=1, write_sel = latched line and write_port = assembled line for exactly one cycle, then IDLE.
- REQ-027: write_sel and write_port SHALL hold their last values outside WRITE; wr_ena=0 outside WRITE.
- REQ-028: Minimum latency: fill_req at cycle 0, beats at cycles 1..8 -> wr_ena at cycle 9, fill_busy low at cycle 10, new fill_req accepted at cycle 10.
- REQ-029: fill_req asserted in the same cycle that WRITE completes SHALL be ignored; it is accepted only when sampled in IDLE.
- REQ-030: All 256 write_port bits SHALL be written each fill; no slot retains data from a prior fill.

Reset
- REQ-031: reset=1 SHALL force IDLE regardless of state, including mid-FILL, with no wr_ena issued for the abandoned fill.
- REQ-032: Reset values: fill_busy=0, mem_ready=0, crit_valid=0, crit_data=0, wr_ena=0, fill_done=0, write_sel=0, write_port=0, beat counter=0.
- REQ-033: reset SHALL take priority over fill_req and mem_valid in the same cycle.

Verification
- REQ-034: fill_req, fill_line=8'h2A, fill_word=0, beats 0x0..0x7 back-to-back -> crit_data=0x0 pulse at cycle 2, wr_ena at cycle 9, write_sel=8'h2A, write_port word k = k.
- REQ-035: fill_word=5, beats 0xA0..0xA7 -> crit_data=0xA0; write_port slots 5,6,7,0,1,2,3,4 = 0xA0..0xA7.
- REQ-036: mem_valid toggled 1/0 each cycle -> counter advances only on valid cycles; wr_ena one cycle after 8th accepted beat; wr_ena never asserted early.
- REQ-037: reset asserted after 4 beats -> IDLE next cycle, no wr_ena/fill_done, all outputs at reset values; subsequent fill completes correctly.
- REQ-038: fill_req held high continuously during a fill with different fill_line -> ignored; second fill starts only from IDLE and writes the line sampled then.
- REQ-039: NL/LSS sweep (LSS=6, fill_line=6'h3F) -> write_sel=6'h3F at wr_ena.
